// File: rtl/mod_if_stage_if.sv
// Instruction-memory fetch handshake between the IF stage (master) and imem (slave).
interface mod_if_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;

    modport master (output imem_req, output imem_addr, input imem_rdy, input imem_data);
    modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_data);
endinterface

// File: rtl/mod_if_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, fetches over a ready handshake,
// buffers one word across decode stalls, applies branch redirects and stops on HLT.
module mod_if_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [15:0] NOP_INSTR   = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 taken,
    input  logic [15:0]          new_pc,
    mod_if_stage_if.master       imem,
    output logic [15:0]          instruction,
    output logic [15:0]          pc,
    output logic                 valid,
    output logic                 halted
);
    localparam int unsigned XLEN = 16;

    typedef enum logic {S_FETCH = 1'b0, S_HALTED = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              hold_valid_q, hold_valid_d;
    logic [XLEN-1:0]   hold_instr_q, hold_instr_d;
    logic [XLEN-1:0]   hold_pc_q, hold_pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
    logic              valid_q, valid_d;

    logic              req_c;
    logic              xfer_c;
    logic              is_hlt_c;
    logic [XLEN-1:0]   fetch_tag_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            hold_valid_q <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
            instr_q      <= NOP_INSTR;
            ifid_pc_q    <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            ifid_pc_q    <= ifid_pc_d;
            valid_q      <= valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        ifid_pc_d    = ifid_pc_q;
        valid_d      = valid_q;

        req_c       = (state_q == S_FETCH) && !hold_valid_q && !rst;
        xfer_c      = req_c && imem.imem_rdy;
        is_hlt_c    = (imem.imem_data[15:12] == HALT_OPCODE);
        fetch_tag_c = XLEN'(pc_q + XLEN'(2));

        if (!stall && taken) begin
            // Redirect wins: squash IF/ID, the held word and any same-cycle fetch.
            instr_d      = NOP_INSTR;
            valid_d      = 1'b0;
            pc_d         = new_pc;
            hold_valid_d = 1'b0;
            state_d      = S_FETCH;
        end else begin
            if (xfer_c) begin
                if (is_hlt_c) state_d = S_HALTED;
                else          pc_d    = fetch_tag_c;
            end
            if (!stall) begin
                if (hold_valid_q) begin
                    instr_d      = hold_instr_q;
                    ifid_pc_d    = hold_pc_q;
                    valid_d      = 1'b1;
                    hold_valid_d = 1'b0;
                end else if (xfer_c) begin
                    instr_d   = imem.imem_data;
                    ifid_pc_d = fetch_tag_c;
                    valid_d   = 1'b1;
                end else begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end else if (xfer_c) begin
                hold_valid_d = 1'b1;
                hold_instr_d = imem.imem_data;
                hold_pc_d    = fetch_tag_c;
            end
        end
    end

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = pc_q;
    assign instruction    = instr_q;
    assign pc             = ifid_pc_q;
    assign valid          = valid_q;
    assign halted         = (state_q == S_HALTED);
endmodule

// File: tb/tb_mod_if_stage.sv
// Randomised and directed checks of mod_if_stage against a transaction-level fetch model.
module tb_mod_if_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        taken;
    logic [15:0] new_pc;
    logic [15:0] instruction;
    logic [15:0] pc;
    logic        valid;
    logic        halted;

    mod_if_stage_if bus();

    mod_if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .taken       (taken),
        .new_pc      (new_pc),
        .imem        (bus.master),
        .instruction (instruction),
        .pc          (pc),
        .valid       (valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Memory image, filled lazily with random words on first read.
    logic [15:0] mem [logic [15:0]];

    // Model: fetch PC, halt flag, hold buffer as a queue of {word, tag}, expected IF/ID.
    logic [15:0] m_pc;
    logic        m_halted;
    logic [31:0] hold_q [$];
    logic [15:0] e_instr, e_pc;
    logic        e_valid;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    function automatic logic m_req();
        return !m_halted && (hold_q.size() == 0);
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_halted = 1'b0; hold_q.delete();
        e_instr = 16'h0000; e_pc = 16'h0000; e_valid = 1'b0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("imem_req",    16'(bus.imem_req), 16'(m_req()));
        chk("imem_addr",   bus.imem_addr,     m_pc);
        chk("instruction", instruction,       e_instr);
        chk("pc",          pc,                e_pc);
        chk("valid",       16'(valid),        16'(e_valid));
        chk("halted",      16'(halted),       16'(m_halted));
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic model_step(input logic s, input logic t, input logic [15:0] np,
                              input logic r, input logic [15:0] w);
        logic        xfer;
        logic [15:0] tag;
        logic [31:0] e;
        xfer = m_req() && r;
        tag  = 16'(m_pc + 16'd2);
        if (!s && t) begin
            e_instr = 16'h0000; e_valid = 1'b0;
            m_pc = np; hold_q.delete(); m_halted = 1'b0;
        end else begin
            if (xfer) begin
                if (w[15:12] == 4'hF) m_halted = 1'b1;
                else                  m_pc = tag;
            end
            if (!s) begin
                if (hold_q.size() != 0) begin
                    e = hold_q.pop_front();
                    e_instr = e[31:16]; e_pc = e[15:0]; e_valid = 1'b1;
                end else if (xfer) begin
                    e_instr = w; e_pc = tag; e_valid = 1'b1;
                end else begin
                    e_instr = 16'h0000; e_valid = 1'b0;
                end
            end else if (xfer) begin
                hold_q.push_back({w, tag});
            end
        end
    endtask

    // Called just after a falling edge: drive inputs, clock once, compare at next falling edge.
    task automatic cycle(input logic s, input logic t, input logic [15:0] np, input logic r);
        logic [15:0] w;
        w = r ? mem_rd(m_pc) : 16'($urandom);
        stall = s; taken = t; new_pc = np;
        bus.imem_rdy = r; bus.imem_data = w;
        model_step(s, t, np, r, w);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; taken = 1'b0; new_pc = 16'h0000;
        bus.imem_rdy = 1'b0; bus.imem_data = 16'h0000;
        model_reset();
        mem[16'h0000] = 16'h1123; mem[16'h0002] = 16'h2456; mem[16'h0004] = 16'h3789;
        for (int a = 6; a < 16; a += 2) mem[16'(a)] = 16'h4000 | 16'(a);
        mem[16'h0008] = 16'h5555;
        mem[16'h0010] = 16'hF000;
        mem[16'h0020] = 16'h1020;
        mem[16'h0040] = 16'h6040; mem[16'h0042] = 16'h6042; mem[16'h0044] = 16'h6044;
        mem[16'hFFFE] = 16'h1AAA; mem[16'h0100] = 16'h2100; mem[16'h0102] = 16'h2102;

        @(negedge clk); @(negedge clk);
        chk("rst_req",   16'(bus.imem_req), 16'h0000);
        chk("rst_valid", 16'(valid),        16'h0000);
        chk("rst_instr", instruction,       16'h0000);
        rst = 1'b0;
        #1 compare_all();
        chk("t1_addr0", bus.imem_addr, 16'h0000);

        // Zero-wait streaming.
        cycle(0, 0, 0, 1); chk("t1_i0", instruction, 16'h1123); chk("t1_p0", pc, 16'h0002);
        cycle(0, 0, 0, 1); chk("t1_i1", instruction, 16'h2456); chk("t1_p1", pc, 16'h0004);
        // Wait states at 0x0004.
        cycle(0, 0, 0, 0); chk("t2_bub0", 16'(valid), 16'h0000); chk("t2_addr", bus.imem_addr, 16'h0004);
        cycle(0, 0, 0, 0); chk("t2_bub1", 16'(valid), 16'h0000);
        cycle(0, 0, 0, 1); chk("t2_i", instruction, 16'h3789); chk("t2_p", pc, 16'h0006);
        // Stall for three cycles with memory ready.
        cycle(1, 0, 0, 1); chk("t3_freeze", instruction, 16'h3789); chk("t3_req", 16'(bus.imem_req), 16'h0000);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 1);
        cycle(0, 0, 0, 1); chk("t3_held", instruction, 16'h4006); chk("t3_hp", pc, 16'h0008);
        cycle(0, 0, 0, 1); chk("t3_next", pc, 16'h000A);
        // Redirect squashing a wrong-path fetch at 0x0008.
        cycle(0, 1, 16'h0008, 1);
        cycle(0, 1, 16'h0040, 1); chk("t4_bub", 16'(valid), 16'h0000); chk("t4_addr", bus.imem_addr, 16'h0040);
        cycle(0, 0, 0, 1); chk("t4_i", instruction, 16'h6040); chk("t4_p", pc, 16'h0042);
        cycle(1, 0, 0, 1);
        cycle(0, 1, 16'h0040, 1); chk("t4_hbub", 16'(valid), 16'h0000);
        cycle(0, 0, 0, 1); chk("t4_hi", instruction, 16'h6040);
        // HLT then restart by redirect.
        cycle(0, 1, 16'h0010, 1);
        cycle(0, 0, 0, 1); chk("t5_i", instruction, 16'hF000); chk("t5_p", pc, 16'h0012);
        chk("t5_halt", 16'(halted), 16'h0001); chk("t5_addr", bus.imem_addr, 16'h0010);
        cycle(0, 0, 0, 1); chk("t5_req", 16'(bus.imem_req), 16'h0000);
        cycle(0, 1, 16'h0020, 1); chk("t5_unhalt", 16'(halted), 16'h0000); chk("t5_addr2", bus.imem_addr, 16'h0020);
        // PC wrap.
        cycle(0, 1, 16'hFFFE, 1);
        cycle(0, 0, 0, 1); chk("wrap_i", instruction, 16'h1AAA); chk("wrap_p", pc, 16'h0000);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom % 4 == 0), 1'($urandom % 10 == 0),
                  16'($urandom) & 16'hFFFE, 1'($urandom % 3 != 0));

        // Asynchronous reset during a wait with the hold buffer full.
        cycle(0, 1, 16'h0100, 1);
        cycle(1, 0, 0, 1);
        cycle(1, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 16'(valid),        16'h0000);
        chk("ar_halt",  16'(halted),       16'h0000);
        chk("ar_req",   16'(bus.imem_req), 16'h0000);
        chk("ar_addr",  bus.imem_addr,     16'h0000);
        model_reset();
        stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 compare_all();
        cycle(0, 0, 0, 1); chk("ar_first", instruction, 16'h1123);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
